// File: rtl/hilo_muldiv.sv
// hilo_muldiv: execute-stage multiply/divide unit producing HI/LO write results.
// MULT/MULTU/MTHI/MTLO finish in one cycle; DIV/DIVU run a WIDTH-step
// restoring shift-subtract loop followed by a sign-fix cycle.
// Optional build macro: HILO_DIV_SHORTCUT_EN (divides with |b| > |a| finish in one cycle).
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             valid_hi,
    output logic [WIDTH-1:0] hi,
    output logic             valid_lo,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CW-1:0]     count_r;
    logic [WIDTH-1:0]  hi_r;      // HI result; partial remainder while dividing
    logic [WIDTH-1:0]  lo_r;      // LO result; dividend/quotient shift register while dividing
    logic [WIDTH-1:0]  div_r;     // divisor magnitude
    logic              vh_r;
    logic              vl_r;
    logic              neg_q_r;   // quotient must be negated in DIV_FIX
    logic              neg_rem_r; // remainder must be negated in DIV_FIX

    logic              accept_s;
    logic              is_div_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [WIDTH-1:0]  a_mag_s;
    logic [WIDTH-1:0]  b_mag_s;
    logic              div_zero_s;
    logic              shortcut_s;
    logic              go_run_s;
    logic [2*WIDTH-1:0] prod_signed_s;
    logic [2*WIDTH-1:0] prod_unsigned_s;
    logic [WIDTH:0]    rem_shift_s;
    logic [WIDTH:0]    diff_s;

    assign accept_s   = start && !flush && ((state_r == IDLE) || (state_r == DONE));
    assign is_div_s   = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg_s    = (op == OP_DIV) && a[WIDTH-1];
    assign b_neg_s    = (op == OP_DIV) && b[WIDTH-1];
    assign a_mag_s    = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
    assign b_mag_s    = b_neg_s ? ({WIDTH{1'b0}} - b) : b;
    assign div_zero_s = (b == {WIDTH{1'b0}});
`ifdef HILO_DIV_SHORTCUT_EN
    assign shortcut_s = (b_mag_s > a_mag_s);
`else
    assign shortcut_s = 1'b0;
`endif
    assign go_run_s   = is_div_s && !div_zero_s && !shortcut_s;

    // Sign-extended operands give the signed product modulo 2^(2*WIDTH).
    assign prod_signed_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_unsigned_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
    // and diff_s[WIDTH] is set exactly when the trial subtraction borrows.
    assign rem_shift_s = {hi_r, lo_r[WIDTH-1]};
    assign diff_s      = rem_shift_s - {1'b0, div_r};

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle start.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        if (go_run_s) begin
                            state_nxt_s = DIV_RUN;
                        end else begin
                            state_nxt_s = DONE;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                DIV_RUN: begin
                    if (count_r == CNT_LAST) begin
                        state_nxt_s = DIV_FIX;
                    end else begin
                        state_nxt_s = DIV_RUN;
                    end
                end
                DIV_FIX: state_nxt_s = DONE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Datapath: operand capture on accept, divide iteration and sign fix-up.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r   <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            div_r     <= '0;
            vh_r      <= 1'b0;
            vl_r      <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        case (op)
                            OP_MULT: begin
                                {hi_r, lo_r} <= prod_signed_s;
                                vh_r <= 1'b1;
                                vl_r <= 1'b1;
                            end
                            OP_MULTU: begin
                                {hi_r, lo_r} <= prod_unsigned_s;
                                vh_r <= 1'b1;
                                vl_r <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                vh_r <= 1'b1;
                                vl_r <= 1'b1;
                                if (div_zero_s) begin
                                    hi_r <= a;
                                    lo_r <= '1;
                                end else if (shortcut_s) begin
                                    hi_r <= a;
                                    lo_r <= '0;
                                end else begin
                                    hi_r      <= '0;
                                    lo_r      <= a_mag_s;
                                    div_r     <= b_mag_s;
                                    neg_q_r   <= a_neg_s ^ b_neg_s;
                                    neg_rem_r <= a_neg_s;
                                    count_r   <= '0;
                                end
                            end
                            OP_MTHI: begin
                                hi_r <= a;
                                lo_r <= '0;
                                vh_r <= 1'b1;
                                vl_r <= 1'b0;
                            end
                            OP_MTLO: begin
                                hi_r <= '0;
                                lo_r <= a;
                                vh_r <= 1'b0;
                                vl_r <= 1'b1;
                            end
                            default: begin
                                hi_r <= '0;
                                lo_r <= '0;
                                vh_r <= 1'b0;
                                vl_r <= 1'b0;
                            end
                        endcase
                    end
                end
                DIV_RUN: begin
                    if (!diff_s[WIDTH]) begin
                        hi_r <= diff_s[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_r <= rem_shift_s[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                    end
                    count_r <= count_r + CNT_ONE;
                end
                DIV_FIX: begin
                    lo_r <= neg_q_r   ? ({WIDTH{1'b0}} - lo_r) : lo_r;
                    hi_r <= neg_rem_r ? ({WIDTH{1'b0}} - hi_r) : hi_r;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Result is presented only in DONE and is masked by a same-cycle flush.
    assign busy     = (state_r == DIV_RUN) || (state_r == DIV_FIX);
    assign done     = (state_r == DONE) && !flush;
    assign valid_hi = done && vh_r;
    assign valid_lo = done && vl_r;
    assign hi       = done ? hi_r : '0;
    assign lo       = done ? lo_r : '0;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed plus randomized checks of hilo_muldiv against an
// arithmetic reference model (native multiply, divide and modulo).
module tb_hilo_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          flush;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          valid_hi;
    logic          valid_lo;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks = 0;
    int errors = 0;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .valid_hi (valid_hi),
        .hi       (hi),
        .valid_lo (valid_lo),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result and timing straight from the architectural definition.
    function automatic void ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] eh, output logic [31:0] el,
                                      output logic evh, output logic evl,
                                      output int elat, output int ebusy);
        longint      sx, sy, q, r;
        logic [63:0] p;
        logic [31:0] ax, ay;
        eh = '0; el = '0; evh = 1'b0; evl = 1'b0; elat = 1; ebusy = 0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q = 0; r = 0; ax = x; ay = y;
        case (o)
            3'd0: begin
                p = 64'(sx * sy);
                eh = p[63:32]; el = p[31:0]; evh = 1'b1; evl = 1'b1;
            end
            3'd1: begin
                p = {32'd0, x} * {32'd0, y};
                eh = p[63:32]; el = p[31:0]; evh = 1'b1; evl = 1'b1;
            end
            3'd2, 3'd3: begin
                evh = 1'b1; evl = 1'b1;
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFF_FFFF;
                end else begin
                    if (o == 3'd2) begin
                        q = sx / sy; r = sx % sy;
                        ax = (sx < 0) ? 32'(-sx) : x;
                        ay = (sy < 0) ? 32'(-sy) : y;
                    end else begin
                        q = longint'({32'd0, x}) / longint'({32'd0, y});
                        r = longint'({32'd0, x}) % longint'({32'd0, y});
                    end
                    el = q[31:0]; eh = r[31:0];
                    elat = 34; ebusy = 33;
`ifdef HILO_DIV_SHORTCUT_EN
                    if (ay > ax) begin
                        elat = 1; ebusy = 0;
                    end
`endif
                end
            end
            3'd4: begin eh = x; evh = 1'b1; end
            3'd5: begin el = x; evl = 1'b1; end
            default: begin eh = '0; el = '0; end
        endcase
    endfunction

    // Issue one operation at the current negedge, wait for done, check everything.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] eh, el;
        logic        evh, evl;
        int          elat, ebusy, lat, bcnt;
        ref_model(o, x, y, eh, el, evh, evl, elat, ebusy);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, " done"},     64'(done),     64'd1);
        check({tag, " latency"},  64'(lat),      64'(elat));
        check({tag, " busy_cyc"}, 64'(bcnt),     64'(ebusy));
        check({tag, " hi"},       64'(hi),       64'(eh));
        check({tag, " lo"},       64'(lo),       64'(el));
        check({tag, " valid_hi"}, 64'(valid_hi), 64'(evh));
        check({tag, " valid_lo"}, 64'(valid_lo), 64'(evl));
    endtask

    // One cycle later with no new request: everything must read zero.
    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " vhi"},  64'(valid_hi), 64'd0);
        check({tag, " vlo"},  64'(valid_lo), 64'd0);
        check({tag, " hi"},   64'(hi), 64'd0);
        check({tag, " lo"},   64'(lo), 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        logic        seen;

        resetn = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi",   64'(hi),   64'd0);
        check("reset lo",   64'(lo),   64'd0);
        check("reset vhi",  64'(valid_hi), 64'd0);
        check("reset vlo",  64'(valid_lo), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        check("mult lo const", 64'(lo), 64'h0000_0000_FFFF_FFFA);
        idle_check("after_mult");

        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
        check("multu hi const", 64'(hi), 64'h0000_0000_0000_0002);
        run_op("mthi_b2b", 3'd4, 32'h0000_1234, 32'hDEAD_BEEF);
        idle_check("after_mthi");

        run_op("div_m7", 3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_m7 lo const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        check("div_m7 hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        idle_check("after_div");
        run_op("divu_m7", 3'd3, 32'hFFFF_FFF9, 32'd2);
        check("divu_m7 lo const", 64'(lo), 64'h0000_0000_7FFF_FFFC);
        check("divu_m7 hi const", 64'(hi), 64'h0000_0000_0000_0001);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf lo const", 64'(lo), 64'h0000_0000_8000_0000);
        run_op("divu_zero", 3'd3, 32'd5, 32'd0);
        run_op("div_zero", 3'd2, 32'hFFFF_FF00, 32'd0);
        idle_check("after_divzero");
        run_op("divu_small", 3'd3, 32'd3, 32'd10);
        check("divu_small hi const", 64'(hi), 64'd3);
        run_op("div_small_neg", 3'd2, 32'hFFFF_FFFD, 32'd100);
        run_op("mtlo", 3'd5, 32'hCAFE_F00D, 32'd1);
        run_op("rsvd6", 3'd6, 32'h1111_2222, 32'h3333_4444);
        run_op("rsvd7", 3'd7, 32'h5555_6666, 32'h7777_8888);
        idle_check("after_rsvd");

        // Flush during the DONE cycle masks the result combinationally.
        op = 3'd0; a = 32'd7; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fdone pre done", 64'(done), 64'd1);
        flush = 1'b1;
        #1;
        check("fdone done", 64'(done), 64'd0);
        check("fdone vhi",  64'(valid_hi), 64'd0);
        check("fdone vlo",  64'(valid_lo), 64'd0);
        check("fdone lo",   64'(lo), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        check("fdone after", 64'(done), 64'd0);

        // Flush wins over a same-cycle start.
        op = 3'd4; a = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start done", 64'(done), 64'd0);

        // Flush on cycle 10 of a divide aborts it with no done.
        op = 3'd2; a = 32'h4000_0000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("fdiv busy pre", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fdiv busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("fdiv no done", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of a divide.
        op = 3'd3; a = 32'hFFFF_0000; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("rdiv busy pre", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        check("rdiv busy", 64'(busy), 64'd0);
        check("rdiv done", 64'(done), 64'd0);
        check("rdiv hi",   64'(hi), 64'd0);
        check("rdiv lo",   64'(lo), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("post_reset", 3'd0, 32'h0001_0000, 32'h0001_0000);

        // Randomized operations, mixing back-to-back and spaced requests.
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 5) == 0) ry = 32'd0;
            else if ($urandom_range(0, 2) == 0) ry = 32'($urandom_range(1, 40));
            if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 50));
            run_op($sformatf("rnd%0d", i), ro, rx, ry);
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d_idle", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage multiply/divide unit; the producer side of the HI/LO write path.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and returns a write_hilo_t-style result: per-register valid bit plus data.
- That result feeds the HILO register file and the decode-stage HI/LO forwarding network.
- Multiply and moves complete in 1 cycle. Divide is a 32-iteration restoring radix-2 FSM.

Parameters:
- WIDTH, 32, operand and HI/LO register width; divide iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled on the rising edge.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are reserved.
- a  in  WIDTH  rs operand (dividend/multiplicand; data for MTHI/MTLO).
- b  in  WIDTH  rt operand (divisor/multiplier).
- flush  in  1  synchronous abort from pipeline control.
- busy  out  1  high while a divide is in flight; execute stage stalls on it.
- done  out  1  one-cycle result pulse.
- valid_hi  out  1  HI write enable, qualified by done.
- hi  out  WIDTH  HI write data.
- valid_lo  out  1  LO write enable, qualified by done.
- lo  out  WIDTH  LO write data.

Behaviour:
- States:
  - IDLE.
  - DIV_RUN: iteration counter 0..WIDTH-1.
  - DIV_FIX.
  - DONE.
- Reset:
  - resetn low puts the FSM in IDLE and clears counter and datapath registers.
  - Outputs are zero immediately, including mid-divide.
- Accept:
  - start is accepted only in IDLE or DONE with flush=0.
  - start is ignored in DIV_RUN/DIV_FIX; the producer must hold off while busy=1.
- busy = (state==DIV_RUN) || (state==DIV_FIX).
- MULT/MULTU:
  - Full 2*WIDTH product is registered on the accept edge; state goes to DONE.
  - hi = product upper half, lo = product lower half, both valid bits set.
  - MULT is signed; MULTU is unsigned.
- MTHI: accept edge goes to DONE; hi=a, valid_hi=1, valid_lo=0, lo=0.
- MTLO: accept edge goes to DONE; lo=a, valid_lo=1, valid_hi=0, hi=0.
- DIV/DIVU, b!=0:
  - Accept edge latches operand magnitudes (DIV: absolute values; DIVU: raw) and the result signs; state goes to DIV_RUN with count=0.
  - Each edge in DIV_RUN performs one shift-subtract step.
  - After WIDTH edges the FSM enters DIV_FIX.
  - DIV_FIX: quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - Next edge goes to DONE.
  - done is first high on the cycle following edge WIDTH+2 after accept (34 cycles for WIDTH=32).
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).
- Divide by zero (b==0), DIV or DIVU: accept edge goes directly to DONE; lo=all ones, hi=a.
- DONE:
  - done=1 for one cycle with the registered result.
  - Next edge goes to IDLE, or to a new operation if start=1 (back-to-back; no bubble).
- Reserved op: accepted; goes to DONE with done=1, both valid bits 0.
- Flush:
  - flush=1 at an edge forces IDLE and discards in-flight work.
  - flush wins over a same-cycle start; the start is dropped.
  - During the DONE cycle, flush combinationally masks done, valid_hi and valid_lo to 0.
- When done=0, valid_hi, valid_lo, hi and lo all read 0.

Optional Feature:
- Macro: HILO_DIV_SHORTCUT_EN.
- Defined:
  - A DIV/DIVU whose divisor magnitude exceeds the dividend magnitude skips iteration: accept edge goes directly to DONE.
  - Result: lo=0, hi=a (original signed value).
  - busy never rises for that operation.
- Undefined: all b!=0 divides take the full WIDTH+2 latency. Results are identical either way; only latency differs.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 -> done on the next cycle; hi=0xFFFFFFFF, lo=0xFFFFFFFA, both valid.
- MULTU a=0xFFFFFFFE, b=3 -> next cycle hi=0x00000002, lo=0xFFFFFFFA; then MTHI a=0x1234 back-to-back -> next cycle valid_hi=1, hi=0x1234, valid_lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy high for 33 cycles; done at cycle 34; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU of the same operands -> lo=0x7FFFFFFC, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> next cycle lo=0xFFFFFFFF, hi=5.
- DIVU a=3, b=10 -> without the macro: 34-cycle latency. With HILO_DIV_SHORTCUT_EN: done next cycle, busy never high. Both give lo=0, hi=3.
- Abort and reset cases:
  - DIV started, flush on cycle 10 -> busy low next cycle, no done.
  - Flush during the DONE cycle -> done and valid bits read 0.
  - resetn pulsed low mid-divide -> all outputs 0 immediately; FSM in IDLE.
